button_debouncer: RTL and testbench

Conditions one raw DE0 push-button input, which is asynchronous, bouncy and active-low, into clean, glitch-free control signals for the LED blinker stage downstream. Sits between the board pin and the blinker's control inputs. It synchronises the input, debounces it with a counter-based state machine, and produces a debounced level, single-cycle press/release/long-press strobes and a press-toggled enable.

---
 rtl/button_debouncer_if.sv | 19 +
 rtl/button_debouncer.sv | 142 ++++++++++++++
 tb/tb_button_debouncer.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/button_debouncer_if.sv
// Board-side button pin and the conditioned control signals handed to the blinker.
interface button_debouncer_if;
  logic btn_raw;
  logic pressed;
  logic press_pulse;
  logic release_pulse;
  logic long_pulse;
  logic toggle;

  modport master (
    output btn_raw,
    input  pressed, press_pulse, release_pulse, long_pulse, toggle
  );

  modport slave (
    input  btn_raw,
    output pressed, press_pulse, release_pulse, long_pulse, toggle
  );
endinterface

// File: rtl/button_debouncer.sv
// Synchronises and debounces one raw push-button into a clean level, press/release/long
// strobes and a press-toggled enable.
module button_debouncer #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int LONG_CYCLES     = 50000000,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic clk,
  input  logic rst,
  button_debouncer_if.slave bus
);
  localparam int DB_W   = $clog2(DEBOUNCE_CYCLES);
  localparam int LONG_W = $clog2(LONG_CYCLES);
  localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  typedef enum logic [2:0] {
    S_RELEASED,
    S_DB_PRESS,
    S_HELD,
    S_LONG_HELD,
    S_DB_RELEASE
  } state_t;

  logic [1:0]        r_sync;
  state_t            r_state,     w_state;
  logic [DB_W-1:0]   r_db_cnt,    w_db_cnt;
  logic [LONG_W-1:0] r_long_cnt,  w_long_cnt;
  logic              r_long_done, w_long_done;
  logic              r_pressed,   w_pressed;
  logic              r_press_pulse, w_press_pulse;
  logic              r_release_pulse, w_release_pulse;
  logic              r_long_pulse, w_long_pulse;
  logic              r_toggle,    w_toggle;
  logic              w_act;

  // Sync flops idle at the released pin level so reset never looks like a press.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_sync <= {2{ACTIVE_LOW}};
    else     r_sync <= {r_sync[0], bus.btn_raw};
  end

  assign w_act = r_sync[1] ^ ACTIVE_LOW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state         <= S_RELEASED;
      r_db_cnt        <= '0;
      r_long_cnt      <= '0;
      r_long_done     <= 1'b0;
      r_pressed       <= 1'b0;
      r_press_pulse   <= 1'b0;
      r_release_pulse <= 1'b0;
      r_long_pulse    <= 1'b0;
      r_toggle        <= 1'b0;
    end else begin
      r_state         <= w_state;
      r_db_cnt        <= w_db_cnt;
      r_long_cnt      <= w_long_cnt;
      r_long_done     <= w_long_done;
      r_pressed       <= w_pressed;
      r_press_pulse   <= w_press_pulse;
      r_release_pulse <= w_release_pulse;
      r_long_pulse    <= w_long_pulse;
      r_toggle        <= w_toggle;
    end
  end

  always_comb begin
    w_state         = r_state;
    w_db_cnt        = r_db_cnt;
    w_long_cnt      = r_long_cnt;
    w_long_done     = r_long_done;
    w_pressed       = r_pressed;
    w_press_pulse   = 1'b0;
    w_release_pulse = 1'b0;
    w_long_pulse    = 1'b0;
    w_toggle        = r_toggle;
    unique case (r_state)
      S_RELEASED: begin
        if (w_act) begin
          w_state  = S_DB_PRESS;
          w_db_cnt = '0;
        end
      end
      S_DB_PRESS: begin
        if (!w_act) begin
          w_state  = S_RELEASED;
          w_db_cnt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state       = S_HELD;
          w_press_pulse = 1'b1;
          w_pressed     = 1'b1;
          w_toggle      = ~r_toggle;
          w_long_cnt    = '0;
          w_long_done   = 1'b0;
        end else begin
          w_db_cnt = r_db_cnt + 1'b1;
        end
      end
      S_HELD: begin
        if (!w_act) begin
          w_state  = S_DB_RELEASE;
          w_db_cnt = '0;
        end else if (r_long_cnt == LONG_LAST) begin
          w_state      = S_LONG_HELD;
          w_long_pulse = 1'b1;
          w_long_done  = 1'b1;
        end else begin
          w_long_cnt = r_long_cnt + 1'b1;
        end
      end
      S_LONG_HELD: begin
        if (!w_act) begin
          w_state  = S_DB_RELEASE;
          w_db_cnt = '0;
        end
      end
      S_DB_RELEASE: begin
        // A bounce resumes the hold where it left off; long_cnt stays frozen meanwhile.
        if (w_act) begin
          w_state  = r_long_done ? S_LONG_HELD : S_HELD;
          w_db_cnt = '0;
        end else if (r_db_cnt == DB_LAST) begin
          w_state         = S_RELEASED;
          w_release_pulse = 1'b1;
          w_pressed       = 1'b0;
          w_db_cnt        = '0;
        end else begin
          w_db_cnt = r_db_cnt + 1'b1;
        end
      end
      default: w_state = S_RELEASED;
    endcase
  end

  assign bus.pressed       = r_pressed;
  assign bus.press_pulse   = r_press_pulse;
  assign bus.release_pulse = r_release_pulse;
  assign bus.long_pulse    = r_long_pulse;
  assign bus.toggle        = r_toggle;
endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, LONG_CYCLES=20, active-low pin.
module tb_button_debouncer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  button_debouncer_if bif ();

  button_debouncer #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (20),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bif)
  );

  always #5 clk = ~clk;

  int compared = 0;
  int failed   = 0;
  int cyc      = 0;
  int n_press, n_rel, n_long, n_multi;
  int t_press, t_rel, t_long;

  // One clock; samples at the falling edge and logs strobe counts and positions.
  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (bif.press_pulse)   begin n_press++; t_press = cyc; end
      if (bif.release_pulse) begin n_rel++;   t_rel   = cyc; end
      if (bif.long_pulse)    begin n_long++;  t_long  = cyc; end
      if (int'(bif.press_pulse) + int'(bif.release_pulse) + int'(bif.long_pulse) > 1) n_multi++;
    end
  endtask

  task automatic clr();
    n_press = 0; n_rel = 0; n_long = 0;
    t_press = -1; t_rel = -1; t_long = -1;
  endtask

  task automatic test_reset();
    bif.btn_raw = 1'b1;
    rst = 1'b1;
    n_multi = 0;
    clr();
    step(3);
    compared++; if (bif.pressed !== 1'b0) begin failed++; $display("FAIL reset_pressed got %b want 0", bif.pressed); end
    compared++; if (bif.toggle !== 1'b0) begin failed++; $display("FAIL reset_toggle got %b want 0", bif.toggle); end
    compared++; if ({bif.press_pulse, bif.release_pulse, bif.long_pulse} !== 3'b000) begin
      failed++; $display("FAIL reset_strobes got %b want 000", {bif.press_pulse, bif.release_pulse, bif.long_pulse}); end
    rst = 1'b0;
    step(5);
    compared++; if (n_press + n_rel + n_long !== 0) begin failed++; $display("FAIL reset_exit_strobes got %0d want 0", n_press + n_rel + n_long); end
    compared++; if (bif.pressed !== 1'b0) begin failed++; $display("FAIL reset_exit_pressed got %b want 0", bif.pressed); end
  endtask

  task automatic test_clean_press();
    int t0;
    clr();
    t0 = cyc; bif.btn_raw = 1'b0;
    step(10);
    compared++; if (n_press !== 1) begin failed++; $display("FAIL press_count got %0d want 1", n_press); end
    compared++; if (t_press - t0 !== 7) begin failed++; $display("FAIL press_latency got %0d want 7", t_press - t0); end
    compared++; if (bif.pressed !== 1'b1) begin failed++; $display("FAIL press_level got %b want 1", bif.pressed); end
    compared++; if (bif.toggle !== 1'b1) begin failed++; $display("FAIL press_toggle got %b want 1", bif.toggle); end
    t0 = cyc; bif.btn_raw = 1'b1;
    step(10);
    compared++; if (n_rel !== 1 || t_rel - t0 !== 7) begin
      failed++; $display("FAIL clean_release got count %0d at %0d want 1 at 7", n_rel, t_rel - t0); end
    compared++; if (bif.pressed !== 1'b0) begin failed++; $display("FAIL clean_release_level got %b want 0", bif.pressed); end
  endtask

  task automatic test_bounce_reject();
    clr();
    bif.btn_raw = 1'b0; step(3);
    bif.btn_raw = 1'b1; step(10);
    compared++; if (n_press + n_rel + n_long !== 0) begin failed++; $display("FAIL bounce_strobes got %0d want 0", n_press + n_rel + n_long); end
    compared++; if (bif.pressed !== 1'b0) begin failed++; $display("FAIL bounce_pressed got %b want 0", bif.pressed); end
    compared++; if (bif.toggle !== 1'b1) begin failed++; $display("FAIL bounce_toggle got %b want 1", bif.toggle); end
  endtask

  task automatic test_release_bounce();
    int t0;
    clr();
    bif.btn_raw = 1'b0; step(10);
    compared++; if (bif.pressed !== 1'b1 || bif.toggle !== 1'b0) begin
      failed++; $display("FAIL relb_press got pressed %b toggle %b want 1 0", bif.pressed, bif.toggle); end
    bif.btn_raw = 1'b1; step(2);
    bif.btn_raw = 1'b0; step(1);
    compared++; if (bif.pressed !== 1'b1) begin failed++; $display("FAIL relb_mid_pressed got %b want 1", bif.pressed); end
    t0 = cyc; bif.btn_raw = 1'b1;
    step(5);
    compared++; if (bif.pressed !== 1'b1 || n_rel !== 0) begin
      failed++; $display("FAIL relb_late_pressed got pressed %b rel %0d want 1 0", bif.pressed, n_rel); end
    step(5);
    compared++; if (n_rel !== 1 || t_rel - t0 !== 7) begin
      failed++; $display("FAIL relb_release got count %0d at %0d want 1 at 7", n_rel, t_rel - t0); end
    compared++; if (bif.pressed !== 1'b0) begin failed++; $display("FAIL relb_final_pressed got %b want 0", bif.pressed); end
  endtask

  task automatic test_long_press();
    clr();
    bif.btn_raw = 1'b0; step(37);
    compared++; if (n_long !== 1) begin failed++; $display("FAIL long_count1 got %0d want 1", n_long); end
    compared++; if (t_long - t_press !== 20) begin failed++; $display("FAIL long_latency1 got %0d want 20", t_long - t_press); end
    bif.btn_raw = 1'b1; step(10);
    bif.btn_raw = 1'b0; step(37);
    compared++; if (n_long !== 2) begin failed++; $display("FAIL long_count2 got %0d want 2", n_long); end
    compared++; if (t_long - t_press !== 20) begin failed++; $display("FAIL long_latency2 got %0d want 20", t_long - t_press); end
    bif.btn_raw = 1'b1; step(10);
    compared++; if (n_rel !== 2 || bif.pressed !== 1'b0) begin
      failed++; $display("FAIL long_release got rel %0d pressed %b want 2 0", n_rel, bif.pressed); end
  endtask

  task automatic test_toggle();
    logic [2:0] exp_seq;
    logic [2:0] got_seq;
    exp_seq = 3'b101;
    clr();
    for (int k = 0; k < 3; k++) begin
      bif.btn_raw = 1'b0; step(10);
      got_seq[2-k] = bif.toggle;
      bif.btn_raw = 1'b1; step(10);
    end
    compared++; if (got_seq !== exp_seq) begin failed++; $display("FAIL toggle_seq got %b want %b", got_seq, exp_seq); end
    compared++; if (n_rel !== 3) begin failed++; $display("FAIL toggle_release_count got %0d want 3", n_rel); end
    compared++; if (n_press !== 3) begin failed++; $display("FAIL toggle_press_count got %0d want 3", n_press); end
  endtask

  task automatic test_reset_mid();
    int t0;
    clr();
    bif.btn_raw = 1'b0; step(5);
    rst = 1'b1;
    #1;
    compared++; if ({bif.pressed, bif.toggle, bif.press_pulse, bif.release_pulse, bif.long_pulse} !== 5'b0) begin
      failed++; $display("FAIL rstmid_outputs got %b want 00000",
        {bif.pressed, bif.toggle, bif.press_pulse, bif.release_pulse, bif.long_pulse}); end
    step(2);
    compared++; if (n_press !== 0) begin failed++; $display("FAIL rstmid_no_press got %0d want 0", n_press); end
    rst = 1'b0; t0 = cyc;
    step(10);
    compared++; if (n_press !== 1 || t_press - t0 !== 7) begin
      failed++; $display("FAIL rstmid_press got count %0d at %0d want 1 at 7", n_press, t_press - t0); end
    compared++; if (bif.toggle !== 1'b1) begin failed++; $display("FAIL rstmid_toggle got %b want 1", bif.toggle); end
    // Reset during a hold must clear the level without a release strobe.
    rst = 1'b1; #1;
    compared++; if (bif.pressed !== 1'b0 || bif.toggle !== 1'b0) begin
      failed++; $display("FAIL rsthold_outputs got pressed %b toggle %b want 0 0", bif.pressed, bif.toggle); end
    bif.btn_raw = 1'b1; step(2);
    rst = 1'b0; step(10);
    compared++; if (n_rel !== 0) begin failed++; $display("FAIL rsthold_release got %0d want 0", n_rel); end
  endtask

  task automatic test_one_strobe();
    compared++; if (n_multi !== 0) begin failed++; $display("FAIL strobe_overlap got %0d want 0", n_multi); end
  endtask

  initial begin
    bif.btn_raw = 1'b1;
    test_reset();
    test_clean_press();
    test_bounce_reject();
    test_release_bounce();
    test_long_press();
    test_toggle();
    test_reset_mid();
    test_one_strobe();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end
endmodule
